// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq shared types and constants
// digit width, add-3 threshold, fsm states
package bin2bcd_seq_pkg;

  localparam int DIG_W = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble cell
// adds 3 to a digit of 5 or more
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= ADD3_TH) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: bit-serial double-dabble
// one binary bit per clock, registered result
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 31,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = DIG_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST =
    ~(DIGITS'(1));

  state_t             state;
  logic [BIN_W-1:0]   sr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [DIGITS-1:0]  blank_nx;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc[g*DIG_W +: DIG_W]),
      .q (adj[g*DIG_W +: DIG_W])
    );
  end

  // leading-zero chain from the top digit down
  always_comb begin
    logic z;
    z = 1'b1;
    blank_nx = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z = z & (acc[k*DIG_W +: DIG_W] == '0);
      blank_nx[k] = z;
    end
  end

  // control fsm, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      blank     <= BLANK_RST;
      overflow  <= 1'b0;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= bin_in;
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          acc <= {adj[ACC_W-2:0], sr[BIN_W-1]};
          sr  <= {sr[BIN_W-2:0], 1'b0};
          ovf <= ovf | adj[ACC_W-1];
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          bcd_out   <= acc;
          overflow  <= ovf;
          blank     <= blank_nx;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench, two configs
// default 31b/10d and 8b/2d
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [30:0] a_bin = '0;
  logic        a_out_valid;
  logic [39:0] a_bcd;
  logic [9:0]  a_blank;
  logic        a_ovf;
  logic        a_busy;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_bin = '0;
  logic        b_out_valid;
  logic [7:0]  b_bcd;
  logic [1:0]  b_blank;
  logic        b_ovf;
  logic        b_busy;

  typedef struct {
    logic [39:0] bcd;
    logic [9:0]  blank;
    logic        ovf;
    int          acc;
  } exp_a_t;

  typedef struct {
    logic [7:0] bcd;
    logic [1:0] blank;
    logic       ovf;
    int         acc;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;
  logic   a_prev = 1'b0;
  logic   b_prev = 1'b0;

  bin2bcd_seq u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .bin_in    (a_bin),
    .out_valid (a_out_valid),
    .bcd_out   (a_bcd),
    .blank     (a_blank),
    .overflow  (a_ovf),
    .busy      (a_busy)
  );

  bin2bcd_seq #(
    .BIN_W  (8),
    .DIGITS (2)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .bin_in    (b_bin),
    .out_valid (b_out_valid),
    .bcd_out   (b_bcd),
    .blank     (b_blank),
    .overflow  (b_ovf),
    .busy      (b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    ncmp++;
    nfail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // monitor for the default config
  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev = 1'b0;
    end else begin
      if (a_prev) chk("a_pulse", a_out_valid, 0);
      if (a_out_valid) begin
        if (qa.size() == 0) begin
          tmo("a_extra_out_valid");
        end else begin
          ea = qa.pop_front();
          chk("a_bcd", a_bcd, ea.bcd);
          chk("a_blank", a_blank, ea.blank);
          chk("a_ovf", a_ovf, ea.ovf);
          chk("a_latency", cyc - ea.acc, 33);
        end
      end
      a_prev = a_out_valid;
    end
  end

  // monitor for the 8b/2d config
  always @(negedge clk) begin
    if (!rst_n) begin
      b_prev = 1'b0;
    end else begin
      if (b_prev) chk("b_pulse", b_out_valid, 0);
      if (b_out_valid) begin
        if (qb.size() == 0) begin
          tmo("b_extra_out_valid");
        end else begin
          eb = qb.pop_front();
          chk("b_bcd", b_bcd, eb.bcd);
          chk("b_blank", b_blank, eb.blank);
          chk("b_ovf", b_ovf, eb.ovf);
          chk("b_latency", cyc - eb.acc, 10);
        end
      end
      b_prev = b_out_valid;
    end
  end

  task automatic send_a(input logic [30:0] v,
                        input logic [39:0] ebcd,
                        input logic [9:0]  ebl,
                        input logic        eo);
    int n = 0;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_bin = v;
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) tmo("a_accept");
    qa.push_back('{ebcd, ebl, eo, cyc});
    @(negedge clk);
    a_in_valid = 1'b0;
    a_bin = 31'h5555_5555;
  endtask

  task automatic send_b(input logic [7:0] v,
                        input logic [7:0] ebcd,
                        input logic [1:0] ebl,
                        input logic       eo);
    int n = 0;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_bin = v;
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) tmo("b_accept");
    qb.push_back('{ebcd, ebl, eo, cyc});
    @(negedge clk);
    b_in_valid = 1'b0;
    b_bin = 8'hA5;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) tmo(nm);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_rst_a(input string nm);
    chk({nm, "_ready"}, a_in_ready, 1);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_ov"}, a_out_valid, 0);
    chk({nm, "_bcd"}, a_bcd, 0);
    chk({nm, "_blank"}, a_blank, 10'h3FE);
    chk({nm, "_ovf"}, a_ovf, 0);
  endtask

  initial begin
    int n;
    int acc1;
    int acc2;
    repeat (3) @(negedge clk);
    chk_rst_a("rst");
    chk("rst_b_blank", b_blank, 2'b10);
    chk("rst_b_bcd", b_bcd, 0);
    rst_n = 1'b1;

    send_a(31'd0, 40'h0, 10'h3FE, 1'b0);
    drain("d0");
    send_a(31'd12345, 40'h00_0001_2345,
           10'b11_1110_0000, 1'b0);
    drain("d1");
    repeat (5) @(negedge clk);
    chk("a_hold", a_bcd, 40'h00_0001_2345);
    send_a(31'd2147483647, 40'h21_4748_3647,
           10'h000, 1'b0);
    send_b(8'd255, 8'h55, 2'b00, 1'b1);
    drain("d2");
    send_b(8'd99, 8'h99, 2'b00, 1'b0);
    drain("d3");
    send_b(8'd100, 8'h00, 2'b10, 1'b1);
    drain("d4");
    send_b(8'd9, 8'h09, 2'b10, 1'b0);
    send_a(31'd1000000000, 40'h10_0000_0000,
           10'h000, 1'b0);
    drain("d5");
    send_a(31'd10, 40'h10, 10'h3FC, 1'b0);
    drain("d6");

    @(negedge clk);
    a_in_valid = 1'b1;
    a_bin = 31'd7;
    n = 0;
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc1 = cyc;
    qa.push_back('{40'h7, 10'h3FE, 1'b0, cyc});
    @(negedge clk);
    a_bin = 31'd42;
    n = 0;
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) tmo("b2b_accept");
    acc2 = cyc;
    qa.push_back('{40'h42, 10'h3FC, 1'b0, cyc});
    chk("b2b_gap", acc2 - acc1, 33);
    @(negedge clk);
    a_in_valid = 1'b0;
    drain("d7");

    @(negedge clk);
    a_in_valid = 1'b1;
    a_bin = 31'd999;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_rst_a("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_rst_a("post");
    send_a(31'd500, 40'h00_0000_0500,
           10'b11_1111_1000, 1'b0);
    drain("d8");
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift/add-3 (double-dabble) algorithm.
- Processes one binary bit per clock instead of a fully unrolled combinational array, trading latency for area.
- Used by the score/timer display path ahead of the 7-segment digit mux.
- Adds a valid/ready handshake, registered outputs, leading-zero blanking flags and overflow detection.

Parameters:
- BIN_W, 31, width of the unsigned binary input (2..64).
- DIGITS, 10, number of BCD output digits (1..20).
- CNT_W, $clog2(BIN_W+1), width of the bit counter (localparam, derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request to convert bin_in.
- in_ready  out  1  block can accept a request (IDLE).
- bin_in  in  BIN_W  unsigned binary value, sampled on accept.
- out_valid  out  1  one-cycle pulse: result registers updated.
- bcd_out  out  4*DIGITS  packed BCD; digit k = bits [4k+3:4k], digit 0 = units.
- blank  out  DIGITS  1 = digit is a leading zero (digit 0 never blanked).
- overflow  out  1  value did not fit in DIGITS digits; bcd_out holds the low DIGITS digits.
- busy  out  1  conversion in progress (SHIFT state).

Behaviour:
- Reset (async assert, sync release): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, bcd_out = 0, blank = {DIGITS-1 ones, 0}, overflow = 0, internal registers = 0.
- States:
  - IDLE: in_ready = 1. On in_valid, load bin_in into the shift register, clear the BCD accumulator, clear sticky ovf, set cnt = BIN_W, go to SHIFT.
  - SHIFT: in_ready = 0, busy = 1. Each cycle:
    - every accumulator digit >= 5 gets +3 (4-bit wrap is impossible after correction);
    - the accumulator shifts left 1, taking the shift register MSB in at bit 0; the shift register shifts left 1;
    - any 1 shifted out of the accumulator top bit sets sticky ovf;
    - cnt decrements. When cnt reaches 1, that shift is the last one and the state goes to DONE.
  - DONE (one cycle): copy the accumulator to bcd_out, ovf to overflow, compute blank, pulse out_valid = 1, go to IDLE.
- Latency: accept edge at cycle 0 -> out_valid high in cycle BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- in_valid during SHIFT or DONE is ignored, not queued. The requester must hold it until in_ready.
- Outputs hold their last values between conversions. Only DONE updates them.
- blank: digit k (k >= 1) is blanked iff digits k..DIGITS-1 are all zero. Computed from the final accumulator, registered with bcd_out.
- Overflow: set iff the binary value >= 10^DIGITS. With the default 10 digits and 31 bits it never sets.
- Reset mid-conversion: conversion aborted, no out_valid, outputs return to reset values.
- bin_in may change after the accept edge without effect.

Decomposition:
- Shared package: BCD digit width constant (4), the add-3 threshold constant (5), and the state enum {IDLE, SHIFT, DONE}.
- Sub-module bcd_digit_adj: a combinational 4-bit "if >= 5 then +3" cell, instantiated DIGITS times via generate.
- The leading-zero blank chain stays inline.

Test Plan:
- Reset release, then bin_in = 0 -> after 32 cycles out_valid = 1, bcd_out = 0, blank = 10'b11_1111_1110, overflow = 0.
- bin_in = 12345 -> bcd_out = 40'h00_0001_2345, blank = 10'b11_1110_0000, out_valid exactly 32 cycles after accept, single-cycle pulse.
- bin_in = 2147483647 -> bcd_out = 40'h21_4748_3647, blank = 0, overflow = 0.
- BIN_W = 8, DIGITS = 2, bin_in = 255 -> bcd_out = 8'h55, overflow = 1. Then bin_in = 99 -> 8'h99, overflow = 0 (sticky cleared per conversion).
- Back-to-back: in_valid held high with values 7 then 42 -> second accept occurs the cycle after the first out_valid. Results are 7 then 42, and in_valid during busy causes no extra conversion.
- rst_n pulsed low mid-SHIFT (cycle 10) -> no out_valid, outputs at reset values, in_ready = 1. A following conversion of 500 gives 40'h00_0000_0500.
